// File: rtl/remote_comm.sv
// remote_comm: host-side UART bridge sending 16-bit commands as two bytes (high first) and receiving single-byte responses.
module remote_comm #(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);
  localparam int CW = $clog2(BAUD_CYCLES + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  state_t state, state_nxt;
  logic [9:0] tx_sr;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_bits;
  logic tx_busy, tx_start, tx_done, bit_end, accept;
  logic [7:0] tx_data, lo_byte;
  logic rx_s1, rx_s2, rx_d, rx_busy, rx_fall, rx_tick, rx_stop;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_bits;
  logic [7:0] rx_sr;
  // The shift register idles all-ones, so its reset drives TX high asynchronously.
  assign TX = tx_sr[0];
  assign bit_end = tx_busy && tx_cnt == BAUD_LAST;
  assign tx_done = bit_end && tx_bits == 4'd9;
  assign accept = state == IDLE && send_cmd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_sr   <= {1'b1, tx_data, 1'b0};
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
      if (bit_end) begin
        tx_sr   <= {1'b1, tx_sr[9:1]};
        tx_bits <= tx_bits + 4'd1;
        tx_busy <= !tx_done;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_data   = cmd[15:8];
    case (state)
      IDLE: if (send_cmd) begin
        tx_start  = 1'b1;
        state_nxt = SEND_HI;
      end
      SEND_HI: if (tx_done) begin
        tx_start  = 1'b1;
        tx_data   = lo_byte;
        state_nxt = SEND_LO;
      end
      SEND_LO: if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo_byte  <= '0;
      cmd_sent <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) lo_byte <= cmd[7:0];
      cmd_sent <= (state == SEND_LO && tx_done) | (cmd_sent & !accept);
    end
  end
  assign rx_fall = !rx_busy && rx_d && !rx_s2;
  assign rx_tick = rx_busy && rx_cnt == '0;
  assign rx_stop = rx_tick && rx_bits == 4'd9;
  // Every sample shifts in; after nine shifts the start bit has fallen out and rx_sr holds the data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sr    <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (rx_fall) begin
        rx_busy <= 1'b1;
        rx_cnt  <= HALF_LAST;
        rx_bits <= '0;
      end else if (rx_busy) begin
        rx_cnt <= rx_tick ? BAUD_LAST : rx_cnt - 1'b1;
        if (rx_tick) begin
          rx_bits <= rx_bits + 4'd1;
          rx_sr   <= {rx_s2, rx_sr[7:1]};
        end
        if (rx_stop) begin
          rx_busy <= 1'b0;
          resp    <= rx_sr;
        end
      end
      resp_rdy <= rx_stop | (resp_rdy & !rx_fall & !accept);
    end
  end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed bench for remote_comm with TX/RX scoreboards and a short baud period.
module tb_remote_comm;
  localparam int B = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx_drv = 1'b1, loop = 1'b0, send_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic TX, cmd_sent, resp_rdy, rx_line;
  logic [7:0] resp;
  int checks = 0, fails = 0, cyc = 0, sent_rises = 0, rdy_rises = 0, rx_start_cyc = 0;
  int t0, s0, r0;
  bit time_chk = 1'b0;
  logic [7:0] tx_q[$], rx_q[$];
  assign rx_line = loop ? TX : rx_drv;
  remote_comm #(.BAUD_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx_line), .TX(TX), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask
  // Decode TX frames at mid-bit and compare against the expected byte queue.
  initial begin : tx_mon
    logic prev, st, sp;
    logic [7:0] b;
    bit ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !TX) begin
        ab = 1'b0;
        repeat (B / 2 - 1) begin @(negedge clk); ab = ab | !rst_n; end
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (B) begin @(negedge clk); ab = ab | !rst_n; end
          b[i] = TX;
        end
        repeat (B) begin @(negedge clk); ab = ab | !rst_n; end
        sp = TX;
        if (!ab) begin
          check("tx_start_bit", {31'b0, st}, 0);
          check("tx_stop_bit", {31'b0, sp}, 1);
          if (tx_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL tx_unexpected_byte observed=%0h expected=none", b);
          end else check("tx_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
        end
      end
      prev = TX;
    end
  end
  initial begin : out_mon
    logic rp, cp;
    rp = 1'b0;
    cp = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !rp) begin
        rdy_rises++;
        if (time_chk) check_rng("resp_rdy_latency", cyc - rx_start_cyc, B * 19 / 2, B * 19 / 2 + 4);
        if (rx_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL resp_unexpected observed=%0h expected=none", resp);
        end else check("resp", {24'b0, resp}, {24'b0, rx_q.pop_front()});
      end
      if (cmd_sent && !cp) sent_rises++;
      rp = resp_rdy;
      cp = cmd_sent;
    end
  end
  task automatic send(input logic [15:0] c, input bit expect_it);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    if (expect_it) begin
      tx_q.push_back(c[15:8]);
      tx_q.push_back(c[7:0]);
    end
    @(negedge clk);
    send_cmd = 1'b0;
  endtask
  task automatic wait_sent(input int start);
    while (!cmd_sent && cyc - start < 30 * B) @(negedge clk);
    check_rng("cmd_sent_latency", cyc - start, 20 * B, 20 * B + 2);
  endtask
  task automatic rx_frame(input logic [7:0] b, input bit chk_clr);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    rx_q.push_back(b);
    time_chk = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      if (i == 0) rx_start_cyc = cyc;
      for (int j = 0; j < B; j++) begin
        @(negedge clk);
        if (chk_clr && i == 0 && j == 4) check("resp_rdy_clear_on_start", {31'b0, resp_rdy}, 0);
      end
    end
  endtask
  initial begin
    repeat (5) @(negedge clk);
    check("reset_tx", {31'b0, TX}, 1);
    check("reset_cmd_sent", {31'b0, cmd_sent}, 0);
    check("reset_resp_rdy", {31'b0, resp_rdy}, 0);
    check("reset_resp", {24'b0, resp}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(16'h2FA5, 1'b1);
    t0 = cyc;
    check("tx_start_after_accept", {31'b0, TX}, 0);
    wait_sent(t0);
    repeat (2 * B) @(negedge clk);
    check("cmd_sent_hold", {31'b0, cmd_sent}, 1);
    check("tx_q_drained_1", tx_q.size(), 0);
    rx_frame(8'hA5, 1'b0);
    repeat (B) @(negedge clk);
    check("resp_rdy_hold", {31'b0, resp_rdy}, 1);
    rx_frame(8'h5A, 1'b1);
    repeat (B) @(negedge clk);
    check("resp_rdy_second", {31'b0, resp_rdy}, 1);
    check("resp_second", {24'b0, resp}, 32'h5A);
    s0 = sent_rises;
    send(16'hABCD, 1'b1);
    t0 = cyc;
    check("resp_rdy_clear_on_send", {31'b0, resp_rdy}, 0);
    check("cmd_sent_clear_on_send", {31'b0, cmd_sent}, 0);
    repeat (3 * B) @(negedge clk);
    send(16'h1234, 1'b0);
    wait_sent(t0);
    repeat (25 * B) @(negedge clk);
    check("cmd_sent_once", sent_rises - s0, 1);
    check("cmd_sent_after_ignore", {31'b0, cmd_sent}, 1);
    check("tx_q_drained_2", tx_q.size(), 0);
    send(16'h3C3C, 1'b1);
    repeat (B + B / 2) @(negedge clk);
    check("tx_mid_frame_low", {31'b0, TX}, 0);
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", {31'b0, TX}, 1);
    repeat (3) @(negedge clk);
    check("reset_mid_cmd_sent", {31'b0, cmd_sent}, 0);
    tx_q.delete();
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("abort_no_cmd_sent", {31'b0, cmd_sent}, 0);
    check("abort_tx_idle", {31'b0, TX}, 1);
    send(16'h0101, 1'b1);
    t0 = cyc;
    wait_sent(t0);
    repeat (B) @(negedge clk);
    check("tx_q_drained_3", tx_q.size(), 0);
    loop = 1'b1;
    time_chk = 1'b0;
    r0 = rdy_rises;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    send(16'h00FF, 1'b1);
    t0 = cyc;
    wait_sent(t0);
    repeat (2 * B) @(negedge clk);
    check("loop_rdy_count", rdy_rises - r0, 2);
    check("loop_resp", {24'b0, resp}, 32'hFF);
    check("rx_q_drained", rx_q.size(), 0);
    check("tx_q_drained_4", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
